// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and response signals of alu_op_sequencer.
// slave is the sequencer's view; master is decode logic plus the ALU facing it.
interface alu_op_sequencer_if #(
  parameter int WIDTH      = 8,
  parameter int FUNC_WIDTH = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [WIDTH-1:0]      req_a;
  logic [WIDTH-1:0]      req_b;
  logic                  req_carry;
  logic                  alu_req;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [FUNC_WIDTH-1:0] alu_func;
  logic                  alu_carry;
  logic                  alu_done;
  logic [WIDTH-1:0]      alu_dout;
  logic                  alu_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_wr;
  logic [3:0]            rsp_flags;
  logic [3:0]            rsp_mask;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_carry, alu_done, alu_dout, alu_cout, rsp_ready,
    output req_ready, alu_req, alu_a, alu_b, alu_func, alu_carry,
           rsp_valid, rsp_result, rsp_wr, rsp_flags, rsp_mask, rsp_err
  );
  modport master (
    output req_valid, req_op, req_a, req_b, req_carry, alu_done, alu_dout, alu_cout, rsp_ready,
    input  req_ready, alu_req, alu_a, alu_b, alu_func, alu_carry,
           rsp_valid, rsp_result, rsp_wr, rsp_flags, rsp_mask, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Maps 6502 ALU ops onto one or two SUM/AND/OR/XOR/SR transactions and builds N/V/Z/C.
// Optional: ALU_SEQ_TIMEOUT_EN aborts a WAIT after TIMEOUT cycles without alu_done.
module alu_op_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FUNC_WIDTH = 3,
  parameter int TIMEOUT    = 15
) (
  input logic               phi1,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);
  localparam logic [FUNC_WIDTH-1:0] F_SUM = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] F_AND = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] F_OR  = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] F_XOR = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] F_SR  = FUNC_WIDTH'(4);

  localparam logic [3:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_AND = 4'd2,  OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4,  OP_CMP = 4'd5,  OP_BIT = 4'd6,  OP_INC = 4'd7;
  localparam logic [3:0] OP_DEC = 4'd8,  OP_ASL = 4'd9,  OP_LSR = 4'd10, OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;

  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP} state_e;
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
  } req_t;

  state_e                state, nxt;
  req_t                  rq;
  logic [WIDTH-1:0]      step_res, res_q;
  logic [3:0]            flags_q, mask_q;
  logic                  wr_q, err_q;
  logic                  legal, alu_act, step2, in_wait, tmo;
  logic [FUNC_WIDTH-1:0] func;
  logic [WIDTH-1:0]      opa, opb;
  logic                  cin, n, v, z, c, wr;
  logic [3:0]            mask;

  assign legal   = (bus.req_op <= OP_ROR);
  assign alu_act = state inside {ISSUE1, WAIT1, ISSUE2, WAIT2};
  assign step2   = state inside {ISSUE2, WAIT2};
  assign in_wait = state inside {WAIT1, WAIT2};

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset)                         cnt <= '0;
    else if (state inside {ISSUE1, ISSUE2}) cnt <= '0;
    else if (in_wait && !bus.alu_done) cnt <= cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th consecutive WAIT cycle without alu_done.
  assign tmo = in_wait && !bus.alu_done && (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid) nxt = legal ? ISSUE1 : RESP;
      ISSUE1:  nxt = WAIT1;
      WAIT1:   if (bus.alu_done) nxt = (rq.op == OP_ROR) ? ISSUE2 : RESP;
               else if (tmo)     nxt = RESP;
      ISSUE2:  nxt = WAIT2;
      WAIT2:   if (bus.alu_done || tmo) nxt = RESP;
      RESP:    if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // ALU operand mapping; the second ROR pass ORs the old carry into the MSB.
  always_comb begin
    func = F_SUM;
    opa  = rq.a;
    opb  = rq.b;
    cin  = rq.carry;
    case (rq.op)
      OP_SBC:         opb = ~rq.b;
      OP_CMP:         begin opb = ~rq.b; cin = 1'b1; end
      OP_AND, OP_BIT: begin func = F_AND; cin = 1'b0; end
      OP_ORA:         begin func = F_OR;  cin = 1'b0; end
      OP_EOR:         begin func = F_XOR; cin = 1'b0; end
      OP_INC:         begin opb = '0; cin = 1'b1; end
      OP_DEC:         begin opb = '1; cin = 1'b0; end
      OP_ASL:         begin opb = rq.a; cin = 1'b0; end
      OP_ROL:         opb = rq.a;
      OP_LSR:         begin func = F_SR; opb = '0; cin = 1'b0; end
      OP_ROR:
        if (step2) begin
          func = F_OR; opa = step_res; opb = {rq.carry, {(WIDTH-1){1'b0}}}; cin = 1'b0;
        end else begin
          func = F_SR; opb = '0; cin = 1'b0;
        end
      default: ;
    endcase
  end

  always_comb begin
    n    = bus.alu_dout[WIDTH-1];
    z    = (bus.alu_dout == '0);
    v    = 1'b0;
    c    = 1'b0;
    mask = 4'b1010;
    wr   = 1'b1;
    case (rq.op)
      OP_ADC, OP_SBC: begin
        v    = (rq.a[WIDTH-1] == opb[WIDTH-1]) && (bus.alu_dout[WIDTH-1] != rq.a[WIDTH-1]);
        c    = bus.alu_cout;
        mask = 4'b1111;
      end
      OP_CMP:         begin c = bus.alu_cout; mask = 4'b1011; wr = 1'b0; end
      OP_BIT:         begin n = rq.b[WIDTH-1]; v = rq.b[WIDTH-2]; mask = 4'b1110; wr = 1'b0; end
      OP_ASL, OP_ROL: begin c = bus.alu_cout; mask = 4'b1011; end
      OP_LSR, OP_ROR: begin c = rq.a[0]; mask = 4'b1011; end
      default: ;
    endcase
  end

  // Response fields are cleared on accept, so an abort only needs to raise err.
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      rq       <= '0;
      step_res <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      rq      <= {bus.req_op, bus.req_a, bus.req_b, bus.req_carry};
      res_q   <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= !legal;
    end else if (in_wait) begin
      if (bus.alu_done && state == WAIT1 && rq.op == OP_ROR) begin
        step_res <= bus.alu_dout;
      end else if (bus.alu_done) begin
        res_q   <= bus.alu_dout;
        flags_q <= {n, v, z, c} & mask;
        mask_q  <= mask;
        wr_q    <= wr;
      end else if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.alu_req    = alu_act;
    bus.alu_a      = alu_act ? opa  : '0;
    bus.alu_b      = alu_act ? opb  : '0;
    bus.alu_func   = alu_act ? func : '0;
    bus.alu_carry  = alu_act & cin;
    bus.rsp_valid  = (state == RESP);
    bus.rsp_result = bus.rsp_valid ? res_q   : '0;
    bus.rsp_flags  = bus.rsp_valid ? flags_q : '0;
    bus.rsp_mask   = bus.rsp_valid ? mask_q  : '0;
    bus.rsp_wr     = bus.rsp_valid & wr_q;
    bus.rsp_err    = bus.rsp_valid & err_q;
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU of programmable latency.
module tb_alu_op_sequencer;
  localparam logic [2:0] F_SUM = 3'd0, F_AND = 3'd1, F_OR = 3'd2, F_XOR = 3'd3, F_SR = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(8), .FUNC_WIDTH(3)) bus ();

  alu_op_sequencer #(.WIDTH(8), .FUNC_WIDTH(3), .TIMEOUT(15)) dut (
    .phi1  (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // ALU model: alu_done rises alu_lat cycles after the first WAIT cycle.
  bit         alu_en  = 1'b1;
  bit         spur    = 1'b0;
  bit         saw_req = 1'b0;
  int         alu_lat = 0;
  int         req_cyc = 0;
  int         ntx     = 0;
  logic [2:0] lg_func [2];
  logic [7:0] lg_a    [2];
  logic [7:0] lg_b    [2];
  logic       lg_c    [2];
  logic [8:0] alu_s;

  always @* begin
    case (bus.alu_func)
      F_SUM:   alu_s = bus.alu_a + bus.alu_b + bus.alu_carry;
      F_AND:   alu_s = {1'b0, bus.alu_a & bus.alu_b};
      F_OR:    alu_s = {1'b0, bus.alu_a | bus.alu_b};
      F_XOR:   alu_s = {1'b0, bus.alu_a ^ bus.alu_b};
      F_SR:    alu_s = {1'b0, bus.alu_a >> 1};
      default: alu_s = 9'h0;
    endcase
  end
  assign bus.alu_dout = alu_s[7:0];
  assign bus.alu_cout = alu_s[8];

  always @(negedge clk) begin
    if (!bus.alu_req) begin
      req_cyc      = 0;
      bus.alu_done = spur;
    end else begin
      saw_req = 1'b1;
      if (bus.alu_done === 1'b1) req_cyc = 1;
      else                       req_cyc++;
      bus.alu_done = alu_en && (req_cyc >= 2 + alu_lat);
      if (bus.alu_done) begin
        if (ntx < 2) begin
          lg_func[ntx] = bus.alu_func;
          lg_a[ntx]    = bus.alu_a;
          lg_b[ntx]    = bus.alu_b;
          lg_c[ntx]    = bus.alu_carry;
        end
        ntx++;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    ntx = 0; saw_req = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_carry = c;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic take();
    chk("busy_in_resp", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_dropped", bus.rsp_valid, 0);
  endtask

  task automatic chk_rsp(input string nm, input logic [7:0] res, input logic [3:0] fl,
                         input logic [3:0] mk, input logic wr, input logic err);
    chk({nm, ".result"}, bus.rsp_result, res);
    chk({nm, ".flags"},  bus.rsp_flags,  fl);
    chk({nm, ".mask"},   bus.rsp_mask,   mk);
    chk({nm, ".wr"},     bus.rsp_wr,     wr);
    chk({nm, ".err"},    bus.rsp_err,    err);
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input int lat, input logic [2:0] f0, input logic [7:0] b0,
                     input logic c0, input int etx, input logic [7:0] res, input logic [3:0] fl,
                     input logic [3:0] mk, input logic wr, input int ecyc);
    int cyc;
    alu_lat = lat;
    send(op, a, b, c);
    wait_rsp(cyc);
    chk({nm, ".cycles"}, cyc, ecyc);
    chk({nm, ".ntx"},    ntx, etx);
    chk({nm, ".func0"},  lg_func[0], f0);
    chk({nm, ".a0"},     lg_a[0], a);
    chk({nm, ".b0"},     lg_b[0], b0);
    chk({nm, ".cin0"},   lg_c[0], c0);
    chk_rsp(nm, res, fl, mk, wr, 1'b0);
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int cyc, nreq;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_carry = 1'b0; bus.rsp_ready = 1'b0;
    #2;
    chk("rst.alu_req", bus.alu_req, 0);
    chk("rst.rsp_valid", bus.rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", bus.req_ready, 1);
    chk_rsp("rst", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("rst.alu_a", bus.alu_a, 0);

    //   name   op     a      b      c  lat f0     b0     c0 ntx res    flags    mask     wr cyc
    run("adc", 4'd0,  8'h50, 8'h50, 0, 0, F_SUM, 8'h50, 0, 1, 8'hA0, 4'b1100, 4'b1111, 1, 3);
    run("sbc", 4'd1,  8'h05, 8'h03, 1, 1, F_SUM, 8'hFC, 1, 1, 8'h02, 4'b0001, 4'b1111, 1, 4);
    run("cmp", 4'd5,  8'h10, 8'h10, 0, 2, F_SUM, 8'hEF, 1, 1, 8'h00, 4'b0011, 4'b1011, 0, 5);
    run("and", 4'd2,  8'hF0, 8'h3C, 1, 0, F_AND, 8'h3C, 0, 1, 8'h30, 4'b0000, 4'b1010, 1, 3);
    run("ora", 4'd3,  8'h80, 8'h01, 0, 0, F_OR,  8'h01, 0, 1, 8'h81, 4'b1000, 4'b1010, 1, 3);
    run("eor", 4'd4,  8'hFF, 8'h0F, 0, 0, F_XOR, 8'h0F, 0, 1, 8'hF0, 4'b1000, 4'b1010, 1, 3);
    run("bit", 4'd6,  8'h0F, 8'hC0, 0, 0, F_AND, 8'hC0, 0, 1, 8'h00, 4'b1110, 4'b1110, 0, 3);
    run("inc", 4'd7,  8'hFF, 8'h12, 0, 0, F_SUM, 8'h00, 1, 1, 8'h00, 4'b0010, 4'b1010, 1, 3);
    run("dec", 4'd8,  8'h01, 8'h12, 1, 0, F_SUM, 8'hFF, 0, 1, 8'h00, 4'b0010, 4'b1010, 1, 3);
    run("asl", 4'd9,  8'h81, 8'h00, 1, 0, F_SUM, 8'h81, 0, 1, 8'h02, 4'b0001, 4'b1011, 1, 3);
    run("rol", 4'd11, 8'h40, 8'h00, 1, 0, F_SUM, 8'h40, 1, 1, 8'h81, 4'b1000, 4'b1011, 1, 3);
    run("lsr", 4'd10, 8'h01, 8'h55, 0, 0, F_SR,  8'h00, 0, 1, 8'h00, 4'b0011, 4'b1011, 1, 3);
    run("ror", 4'd12, 8'h01, 8'h00, 1, 0, F_SR,  8'h00, 0, 2, 8'h80, 4'b1001, 4'b1011, 1, 5);
    chk("ror.func1", lg_func[1], F_OR);
    chk("ror.a1", lg_a[1], 8'h00);
    chk("ror.b1", lg_b[1], 8'h80);
    run("ror_slow", 4'd12, 8'h02, 8'h00, 0, 1, F_SR, 8'h00, 0, 2, 8'h01, 4'b0000, 4'b1011, 1, 7);

    // Illegal op answers immediately and holds while the consumer stalls.
    send(4'hE, 8'h12, 8'h34, 1'b1);
    wait_rsp(cyc);
    chk("ill.cycles", cyc, 1);
    chk_rsp("ill", 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ill.hold_valid", bus.rsp_valid, 1);
      chk("ill.hold_err", bus.rsp_err, 1);
      chk("ill.hold_result", bus.rsp_result, 0);
    end
    chk("ill.no_alu", saw_req, 0);
    take();

    // alu_done with no transaction open must not move the sequencer.
    spur = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur.req_ready", bus.req_ready, 1);
    chk("spur.rsp_valid", bus.rsp_valid, 0);
    chk("spur.alu_req", bus.alu_req, 0);
    spur = 1'b0;
    @(negedge clk);

`ifdef ALU_SEQ_TIMEOUT_EN
    alu_en = 1'b0;
    send(4'd0, 8'h01, 8'h02, 1'b0);
    nreq = 0; cyc = 1;
    while (!bus.rsp_valid && cyc < 100) begin
      if (bus.alu_req) nreq++;
      @(negedge clk);
      cyc++;
    end
    chk("tmo.req_cycles", nreq, 16);
    chk("tmo.alu_req", bus.alu_req, 0);
    chk_rsp("tmo", 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
    take();
    alu_en = 1'b1;
`else
    alu_en = 1'b0;
    send(4'd0, 8'h01, 8'h02, 1'b0);
    repeat (30) @(negedge clk);
    chk("stall.alu_req", bus.alu_req, 1);
    chk("stall.rsp_valid", bus.rsp_valid, 0);
    alu_en = 1'b1;
    wait_rsp(cyc);
    chk("stall.done", bus.rsp_valid, 1);
    chk_rsp("stall", 8'h03, 4'b0000, 4'b1111, 1'b1, 1'b0);
    take();
    nreq = 0;
`endif

    // Asynchronous reset in WAIT1 abandons the transaction at once.
    alu_en = 1'b0;
    send(4'd0, 8'h33, 8'h44, 1'b0);
    @(negedge clk);
    chk("arst.pre_alu_req", bus.alu_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.alu_req", bus.alu_req, 0);
    chk("arst.rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    alu_en = 1'b1;
    @(negedge clk);
    chk("arst.rsp_after", bus.rsp_valid, 0);
    run("post_rst", 4'd0, 8'h01, 8'h01, 0, 0, F_SUM, 8'h01, 0, 1, 8'h02, 4'b0000, 4'b1111, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
